// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared sync phase type and 640x480@60 default timing for all video blocks
package vga_timing_pkg;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_e;
  localparam int DEF_CNT_WIDTH   = 10;
  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;
endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one timing axis, position counter plus ACTIVE/FRONT/SYNC/BACK phase tracking
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int ACTIVE_LEN = DEF_ACTIVE_COLS,
  parameter int FRONT_LEN  = DEF_H_FRONT,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BACK_LEN   = DEF_H_BACK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  output logic [CNT_WIDTH-1:0] cnt,
  output phase_e               phase_nxt,
  output logic                 wrap
);
  localparam logic [CNT_WIDTH-1:0] LAST     = CNT_WIDTH'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] FRONT_AT = CNT_WIDTH'(ACTIVE_LEN);
  localparam logic [CNT_WIDTH-1:0] SYNC_AT  = CNT_WIDTH'(ACTIVE_LEN + FRONT_LEN);
  localparam logic [CNT_WIDTH-1:0] BACK_AT  = CNT_WIDTH'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);
  phase_e               phase;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  assign wrap = cnt == LAST;
  // later boundaries are tested first so zero-length phases are skipped cleanly
  always_comb begin
    cnt_nxt   = adv ? (wrap ? '0 : cnt + 1'b1) : cnt;
    phase_nxt = !adv                 ? phase  :
                cnt_nxt == BACK_AT   ? BACK   :
                cnt_nxt == SYNC_AT   ? SYNC   :
                cnt_nxt == FRONT_AT  ? FRONT  :
                cnt_nxt == '0        ? ACTIVE : phase;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= LAST;
      phase <= BACK;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing source with registered, mutually aligned sync/position outputs
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int TOTAL_COLS      = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS      = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS     = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS     = DEF_ACTIVE_ROWS,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_active,
  output logic [CNT_WIDTH-1:0] o_col,
  output logic [CNT_WIDTH-1:0] o_row,
  output logic                 o_line_start,
  output logic                 o_frame_start
);
  localparam logic IDLE_LVL = SYNC_ACTIVE_LOW;
  if (ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK != TOTAL_COLS) begin : g_bad_cols
    $error("vga_sync_gen: horizontal phase lengths do not sum to TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK != TOTAL_ROWS) begin : g_bad_rows
    $error("vga_sync_gen: vertical phase lengths do not sum to TOTAL_ROWS");
  end
  if (TOTAL_COLS > 2**CNT_WIDTH || TOTAL_ROWS > 2**CNT_WIDTH) begin : g_bad_width
    $error("vga_sync_gen: CNT_WIDTH too small for TOTAL_COLS/TOTAL_ROWS");
  end
  phase_e h_nxt, v_nxt;
  logic   h_wrap, v_wrap;
  vga_axis_timer #(
    .CNT_WIDTH(CNT_WIDTH), .ACTIVE_LEN(ACTIVE_COLS), .FRONT_LEN(H_FRONT),
    .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h (
    .clk(clk), .rst_n(i_rst_n), .adv(i_enable),
    .cnt(o_col), .phase_nxt(h_nxt), .wrap(h_wrap)
  );
  vga_axis_timer #(
    .CNT_WIDTH(CNT_WIDTH), .ACTIVE_LEN(ACTIVE_ROWS), .FRONT_LEN(V_FRONT),
    .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v (
    .clk(clk), .rst_n(i_rst_n), .adv(i_enable && h_wrap),
    .cnt(o_row), .phase_nxt(v_nxt), .wrap(v_wrap)
  );
  // decode from next-phase so the registered outputs line up with the counters
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync       <= IDLE_LVL;
      o_vsync       <= IDLE_LVL;
      o_active      <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= (h_nxt == SYNC) ^ IDLE_LVL;
      o_vsync       <= (v_nxt == SYNC) ^ IDLE_LVL;
      o_active      <= h_nxt == ACTIVE && v_nxt == ACTIVE;
      o_line_start  <= i_enable && h_wrap;
      o_frame_start <= i_enable && h_wrap && v_wrap;
    end
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Free-running VGA timing generator. It produces horizontal and vertical sync pulses, an active-video flag, and column/row position for every pixel clock. It is the source end of the sync interface: its `o_hsync`/`o_vsync` drive the `i_hsync`/`i_vsync` inputs of the pattern generator and any other sync-consuming video stage. Default timing is 640x480 @ 60 Hz, 800x525 total, on a 25.175 MHz pixel clock.

## Interface
- `CNT_WIDTH`, 10 — width of the column and row counters; must hold `TOTAL_COLS-1` and `TOTAL_ROWS-1`.
- `TOTAL_COLS`, 800 — pixel clocks per line.
- `TOTAL_ROWS`, 525 — lines per frame.
- `ACTIVE_COLS`, 640 — visible pixels per line.
- `ACTIVE_ROWS`, 480 — visible lines per frame.
- `H_FRONT` = 16, `H_SYNC` = 96, `H_BACK` = 48 — horizontal porch and sync lengths, in clocks.
- `V_FRONT` = 10, `V_SYNC` = 2, `V_BACK` = 33 — vertical porch and sync lengths, in lines.
- `SYNC_ACTIVE_LOW`, 1 — 1: sync pulses are driven low; 0: sync pulses are driven high.
- `clk` in 1 — pixel clock; the only clock.
- `i_rst_n` in 1 — reset; asynchronous assert, active-low.
- `i_enable` in 1 — advance timing while high; freeze while low.
- `o_hsync` out 1 — horizontal sync, polarity per `SYNC_ACTIVE_LOW`.
- `o_vsync` out 1 — vertical sync, polarity per `SYNC_ACTIVE_LOW`.
- `o_active` out 1 — current pixel is visible.
- `o_col` out `CNT_WIDTH` — current column, 0..`TOTAL_COLS-1`.
- `o_row` out `CNT_WIDTH` — current row, 0..`TOTAL_ROWS-1`.
- `o_line_start` out 1 — one-cycle pulse when `o_col` has just advanced to 0.
- `o_frame_start` out 1 — one-cycle pulse when `o_col` and `o_row` have both just advanced to 0.

## Operation
- Parameter legality:
  - `ACTIVE_COLS+H_FRONT+H_SYNC+H_BACK == TOTAL_COLS`.
  - `ACTIVE_ROWS+V_FRONT+V_SYNC+V_BACK == TOTAL_ROWS`.
  - Violating either raises an elaboration-time error.
- Each axis has its own phase FSM: `ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE`.
  - Horizontal phase boundaries are at col `ACTIVE_COLS`, `ACTIVE_COLS+H_FRONT`, `ACTIVE_COLS+H_FRONT+H_SYNC`, and wrap at 0.
  - Vertical phase boundaries are the same pattern in rows.
- The horizontal axis advances on every enabled clock.
  - `o_col` wraps `TOTAL_COLS-1 -> 0`.
  - On that wrap, the vertical axis advances one row; `o_row` wraps `TOTAL_ROWS-1 -> 0`.
- Output decode:
  - `o_hsync` is asserted (active level) iff the H phase is `SYNC`.
  - `o_vsync` is asserted iff the V phase is `SYNC`. It spans whole lines and changes only coincident with `o_col` becoming 0.
  - `o_active` = (H phase is `ACTIVE`) && (V phase is `ACTIVE`).
- `i_enable` low: counters, phases, `o_hsync`, `o_vsync` and `o_active` hold their values; `o_line_start` and `o_frame_start` are 0.
- Reset state is the last pixel of a frame:
  - `o_col` = `TOTAL_COLS-1`, `o_row` = `TOTAL_ROWS-1`.
  - Both FSMs are in `BACK`.
  - `o_hsync` and `o_vsync` are at their inactive level; `o_active` = 0.
  - `o_line_start` = 0, `o_frame_start` = 0.
- Reset is honoured at any point mid-frame: all state returns to the reset values immediately, with no partial-line completion.

## Timing
- All outputs are registered and mutually aligned: every output reflects the current `o_col`/`o_row` in the same cycle, with no decode skew.
- After `i_rst_n` deasserts, the first enabled edge gives `o_col` = 0, `o_row` = 0, `o_active` = 1, `o_line_start` = 1, `o_frame_start` = 1.
- Reset assertion is asynchronous; deassertion must be synchronized externally to `clk`.
- The first enabled edge after a freeze resumes from the held position; no cycle is skipped or repeated.
- Pulse widths and periods (defaults):
  - `o_hsync` is asserted for cols 656..751 (96 clocks); line period is 800 clocks.
  - `o_vsync` is asserted for rows 490..491 (1600 clocks); frame period is 420000 enabled clocks.

## Structure
- Shared package `vga_timing_pkg` holds:
  - The phase enum (`ACTIVE`, `FRONT`, `SYNC`, `BACK`).
  - The 640x480@60 default constants, so that `vga_sync_gen` and all downstream video blocks draw their defaults from one place.
- Sub-module `vga_axis_timer` provides one counter plus phase FSM, parameterized by active/front/sync/back lengths, with an advance input and wrap output.
  - It is instantiated twice: horizontal, advanced by `i_enable`; vertical, advanced by the horizontal wrap AND `i_enable`.
  - Top-level logic handles sync polarity, `o_active`, and the start pulses.

## Test plan
- Reset check: hold `i_rst_n` low -> `o_col`=799, `o_row`=524, `o_hsync`=`o_vsync`=1 (active-low default), `o_active`=0, both pulses 0.
- Startup: release reset, `i_enable`=1, one edge -> `o_col`=0, `o_row`=0, `o_active`=1, `o_frame_start`=1, `o_line_start`=1; on the next edge `o_col`=1 and both pulses are 0.
- Horizontal timing over one line:
  - `o_hsync` = 0 exactly for cols 656..751.
  - `o_active` falls at col 640 and rises at col 0.
  - `o_line_start` pulses every 800 clocks.
- Vertical timing over one full frame (420000 clocks):
  - `o_vsync` = 0 for 1600 consecutive clocks, beginning at row 490 col 0.
  - `o_active` = 0 for all rows ≥ 480.
  - Exactly one `o_frame_start`.
- Freeze: drop `i_enable` for 37 clocks at row 100 col 300 -> all outputs hold, pulses stay 0; on re-enable, `o_col`=301 at the first edge.
- Mid-frame reset: assert `i_rst_n` low at row 491 col 700, while `o_vsync` and `o_hsync` are asserted -> both go inactive immediately, all reset values appear, and the startup sequence repeats on release.
